// File: rtl/lemonpc_pkg.sv
// Shared LemonPC core constants: XLEN, register index width, x0 index and read-bus packing widths.
package lemonpc_pkg;

  localparam int unsigned XLEN       = 64;
  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned NR_REGS    = 2 ** REG_ADDR_W;

  localparam logic [REG_ADDR_W-1:0] X0_IDX = '0;

  localparam int unsigned DEF_NR_READ  = 2;
  localparam int unsigned DEF_NR_WRITE = 1;

  // Width of a packed bus of nr_ports read addresses (decode builds the same bus).
  function automatic int unsigned rd_addr_bus_w(input int unsigned nr_ports,
                                                input int unsigned addr_w);
    return nr_ports * addr_w;
  endfunction

  // Width of a packed bus of nr_ports read data words.
  function automatic int unsigned rd_data_bus_w(input int unsigned nr_ports,
                                                input int unsigned data_w);
    return nr_ports * data_w;
  endfunction

endpackage

// File: rtl/regfile_rdport.sv
// One combinational read port of regfile_mp: address mux, x0 forcing and,
// when REGFILE_BYPASS_EN is defined, the write-to-read bypass compare chain.
module regfile_rdport
  import lemonpc_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = REG_ADDR_W,
  parameter int unsigned DATA_WIDTH = XLEN,
  parameter int unsigned NR_WRITE   = DEF_NR_WRITE
) (
  input  logic [ADDR_WIDTH-1:0]          addr,
  input  logic [DATA_WIDTH-1:0]          rf [2**ADDR_WIDTH],
  input  logic [2**ADDR_WIDTH-1:0]       busy,
  input  logic [NR_WRITE-1:0]            wb_en,
  input  logic [NR_WRITE*ADDR_WIDTH-1:0] wb_addr,
  input  logic [NR_WRITE*DATA_WIDTH-1:0] wb_data,
  input  logic                           iss_valid,
  input  logic [ADDR_WIDTH-1:0]          iss_rd,
  output logic [DATA_WIDTH-1:0]          rd_data_c,
  output logic                           rd_busy_c
);

  logic is_x0;
  assign is_x0 = (addr == ADDR_WIDTH'(X0_IDX));

`ifdef REGFILE_BYPASS_EN
  logic                  hit;
  logic [DATA_WIDTH-1:0] byp_data;

  // Find the highest-indexed write port targeting this address this cycle.
  always_comb begin
    hit      = 1'b0;
    byp_data = '0;
    for (int unsigned j = 0; j < NR_WRITE; j++) begin
      if (wb_en[j] && (wb_addr[j*ADDR_WIDTH +: ADDR_WIDTH] == addr)) begin
        hit      = 1'b1;
        byp_data = wb_data[j*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Array read, overridden by bypass; a same-cycle reissue keeps the register busy.
  always_comb begin
    rd_data_c = rf[addr];
    rd_busy_c = busy[addr];
    if (hit) begin
      rd_data_c = byp_data;
      rd_busy_c = iss_valid && (iss_rd == addr);
    end
    if (is_x0) begin
      rd_data_c = '0;
      rd_busy_c = 1'b0;
    end
  end
`else
  // Write and issue inputs only feed the bypass path.
  logic unused_bypass;
  assign unused_bypass = ^{wb_en, wb_addr, wb_data, iss_valid, iss_rd};

  // Plain array read with x0 forced to zero / not busy.
  always_comb begin
    rd_data_c = rf[addr];
    rd_busy_c = busy[addr];
    if (is_x0) begin
      rd_data_c = '0;
      rd_busy_c = 1'b0;
    end
  end
`endif

endmodule

// File: rtl/regfile_mp.sv
// Multi-port integer register file with pending-write scoreboard.
// Optional write-to-read bypass selected by defining REGFILE_BYPASS_EN.
module regfile_mp
  import lemonpc_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = REG_ADDR_W,
  parameter int unsigned DATA_WIDTH = XLEN,
  parameter int unsigned NR_READ    = DEF_NR_READ,
  parameter int unsigned NR_WRITE   = DEF_NR_WRITE
) (
  input  logic                                              clk,
  input  logic                                              rst,
  input  logic [rd_addr_bus_w(NR_READ, ADDR_WIDTH)-1:0]     rd_addr,
  output logic [rd_data_bus_w(NR_READ, DATA_WIDTH)-1:0]     rd_data,
  output logic [NR_READ-1:0]                                rd_busy,
  input  logic                                              iss_valid,
  input  logic [ADDR_WIDTH-1:0]                             iss_rd,
  input  logic [NR_WRITE-1:0]                               wb_en,
  input  logic [NR_WRITE*ADDR_WIDTH-1:0]                    wb_addr,
  input  logic [NR_WRITE*DATA_WIDTH-1:0]                    wb_data
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] rf [DEPTH];
  logic [DEPTH-1:0]      busy;
  logic [DEPTH-1:0]      busy_nxt;

  // Array write: ports applied in ascending order so the highest port wins; x0 discarded.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        rf[i] <= '0;
      end
    end else begin
      for (int unsigned j = 0; j < NR_WRITE; j++) begin
        if (wb_en[j] && (wb_addr[j*ADDR_WIDTH +: ADDR_WIDTH] != ADDR_WIDTH'(X0_IDX))) begin
          rf[wb_addr[j*ADDR_WIDTH +: ADDR_WIDTH]] <= wb_data[j*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end
  end

  // Scoreboard next state: writebacks clear, then an issue sets (set wins); x0 never busy.
  always_comb begin
    busy_nxt = busy;
    for (int unsigned j = 0; j < NR_WRITE; j++) begin
      if (wb_en[j]) begin
        busy_nxt[wb_addr[j*ADDR_WIDTH +: ADDR_WIDTH]] = 1'b0;
      end
    end
    if (iss_valid) begin
      busy_nxt[iss_rd] = 1'b1;
    end
    busy_nxt[X0_IDX] = 1'b0;
  end

  // Scoreboard register.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= '0;
    end else begin
      busy <= busy_nxt;
    end
  end

  // One combinational read port per decode operand.
  for (genvar k = 0; k < int'(NR_READ); k++) begin : g_rd
    regfile_rdport #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .DATA_WIDTH (DATA_WIDTH),
      .NR_WRITE   (NR_WRITE)
    ) u_rdport (
      .addr      (rd_addr[k*ADDR_WIDTH +: ADDR_WIDTH]),
      .rf        (rf),
      .busy      (busy),
      .wb_en     (wb_en),
      .wb_addr   (wb_addr),
      .wb_data   (wb_data),
      .iss_valid (iss_valid),
      .iss_rd    (iss_rd),
      .rd_data_c (rd_data[k*DATA_WIDTH +: DATA_WIDTH]),
      .rd_busy_c (rd_busy[k])
    );
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp (3 read ports, 2 write ports); follows REGFILE_BYPASS_EN.
module tb_regfile_mp;

  localparam int unsigned AW    = 5;
  localparam int unsigned DW    = 64;
  localparam int unsigned NR    = 3;
  localparam int unsigned NW    = 2;
  localparam int unsigned DEPTH = 2 ** AW;

  logic              clk = 1'b0;
  logic              rst;
  logic [NR*AW-1:0]  rd_addr;
  logic [NR*DW-1:0]  rd_data;
  logic [NR-1:0]     rd_busy;
  logic              iss_valid;
  logic [AW-1:0]     iss_rd;
  logic [NW-1:0]     wb_en;
  logic [NW*AW-1:0]  wb_addr;
  logic [NW*DW-1:0]  wb_data;

  int n_checks = 0;
  int n_pass   = 0;

  logic [DW-1:0] m_rf   [DEPTH];
  logic          m_busy [DEPTH];

  logic [DW-1:0] exp_data_q [$];
  logic          exp_busy_q [$];

  always #5 clk = ~clk;

  regfile_mp #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .NR_READ    (NR),
    .NR_WRITE   (NW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .rd_busy   (rd_busy),
    .iss_valid (iss_valid),
    .iss_rd    (iss_rd),
    .wb_en     (wb_en),
    .wb_addr   (wb_addr),
    .wb_data   (wb_data)
  );

  // Single comparison point: counts and reports.
  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      n_pass++;
    end
  endtask

  task automatic set_rd(input int k, input logic [AW-1:0] a);
    rd_addr[k*AW +: AW] = a;
  endtask

  task automatic set_wb(input int j, input logic en, input logic [AW-1:0] a, input logic [DW-1:0] d);
    wb_en[j]            = en;
    wb_addr[j*AW +: AW] = a;
    wb_data[j*DW +: DW] = d;
  endtask

  task automatic idle_inputs();
    iss_valid = 1'b0;
    iss_rd    = '0;
    wb_en     = '0;
    wb_addr   = '0;
    wb_data   = '0;
  endtask

  // Expected combinational read for the currently driven inputs.
  task automatic model_read(input logic [AW-1:0] a, output logic [DW-1:0] d, output logic b);
    logic hit;
    d   = m_rf[a];
    b   = m_busy[a];
    hit = 1'b0;
`ifdef REGFILE_BYPASS_EN
    for (int j = 0; j < int'(NW); j++) begin
      if (wb_en[j] && wb_addr[j*AW +: AW] == a) begin
        hit = 1'b1;
        d   = wb_data[j*DW +: DW];
      end
    end
    if (hit) b = iss_valid && (iss_rd == a);
`endif
    if (a == '0) begin
      d = '0;
      b = 1'b0;
    end
  endtask

  // Edge update of the reference array and scoreboard.
  task automatic model_edge();
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        m_rf[i]   = '0;
        m_busy[i] = 1'b0;
      end
    end else begin
      for (int j = 0; j < int'(NW); j++) begin
        if (wb_en[j]) begin
          if (wb_addr[j*AW +: AW] != '0) m_rf[wb_addr[j*AW +: AW]] = wb_data[j*DW +: DW];
          m_busy[wb_addr[j*AW +: AW]] = 1'b0;
        end
      end
      if (iss_valid && iss_rd != '0) m_busy[iss_rd] = 1'b1;
    end
  endtask

  // One cycle: push expectations, compare at negedge, advance model, cross the edge.
  task automatic cycle();
    logic [DW-1:0] d;
    logic          b;
    for (int k = 0; k < int'(NR); k++) begin
      model_read(rd_addr[k*AW +: AW], d, b);
      exp_data_q.push_back(d);
      exp_busy_q.push_back(b);
    end
    @(negedge clk);
    for (int k = 0; k < int'(NR); k++) begin
      check($sformatf("rd_data[%0d]", k), rd_data[k*DW +: DW], exp_data_q.pop_front());
      check($sformatf("rd_busy[%0d]", k), DW'(rd_busy[k]), DW'(exp_busy_q.pop_front()));
    end
    model_edge();
    @(posedge clk);
    #1;
  endtask

  // Direct check of one port against a hand-derived constant.
  task automatic chk_now(input string tag, input int k, input logic [DW-1:0] d, input logic b);
    #1;
    check({tag, "_data"}, rd_data[k*DW +: DW], d);
    check({tag, "_busy"}, DW'(rd_busy[k]), DW'(b));
  endtask

  initial begin
    rst     = 1'b1;
    rd_addr = '0;
    idle_inputs();
    set_wb(0, 1'b1, AW'(5), 64'hAA);
    for (int i = 0; i < int'(DEPTH); i++) begin
      m_rf[i]   = '0;
      m_busy[i] = 1'b0;
    end
    @(posedge clk);
    #1;
    set_rd(0, AW'(5));
    cycle();
    rst = 1'b0;
    idle_inputs();

    // Everything reads zero and idle after reset, x5 write discarded.
    set_rd(0, AW'(5));
    chk_now("x5_after_rst", 0, 64'h0, 1'b0);
    for (int a = 0; a < int'(DEPTH); a += int'(NR)) begin
      for (int k = 0; k < int'(NR); k++) set_rd(k, AW'((a + k) % int'(DEPTH)));
      cycle();
    end

    // Basic write of x3, visible next cycle on all ports.
    set_wb(0, 1'b1, AW'(3), 64'h1234);
    cycle();
    idle_inputs();
    for (int k = 0; k < int'(NR); k++) set_rd(k, AW'(3));
    chk_now("x3_port0", 0, 64'h1234, 1'b0);
    chk_now("x3_port2", 2, 64'h1234, 1'b0);
    cycle();

    // x0 write discarded.
    set_wb(0, 1'b1, AW'(0), 64'hFFFF);
    cycle();
    idle_inputs();
    set_rd(0, AW'(0));
    chk_now("x0_read", 0, 64'h0, 1'b0);
    cycle();

    // Scoreboard: issue x7, writeback two cycles later.
    for (int k = 0; k < int'(NR); k++) set_rd(k, AW'(7));
    iss_valid = 1'b1;
    iss_rd    = AW'(7);
    cycle();
    idle_inputs();
    chk_now("x7_busy1", 0, 64'h0, 1'b1);
    cycle();
    chk_now("x7_busy2", 1, 64'h0, 1'b1);
    set_wb(1, 1'b1, AW'(7), 64'h55);
`ifdef REGFILE_BYPASS_EN
    chk_now("x7_wb_cycle", 0, 64'h55, 1'b0);
`else
    chk_now("x7_wb_cycle", 0, 64'h0, 1'b1);
`endif
    cycle();
    idle_inputs();
    chk_now("x7_done", 0, 64'h55, 1'b0);
    cycle();

    // Issue and writeback x9 in the same cycle: busy stays set, data updates.
    for (int k = 0; k < int'(NR); k++) set_rd(k, AW'(9));
    iss_valid = 1'b1;
    iss_rd    = AW'(9);
    set_wb(0, 1'b1, AW'(9), 64'h99);
    cycle();
    idle_inputs();
    chk_now("x9_set_wins", 0, 64'h99, 1'b1);
    cycle();
    set_wb(0, 1'b1, AW'(9), 64'h9A);
    cycle();
    idle_inputs();

    // Dual write to x4: higher port wins.
    for (int k = 0; k < int'(NR); k++) set_rd(k, AW'(4));
    set_wb(0, 1'b1, AW'(4), 64'h1);
    set_wb(1, 1'b1, AW'(4), 64'h2);
`ifdef REGFILE_BYPASS_EN
    chk_now("x4_same_cycle", 0, 64'h2, 1'b0);
`else
    chk_now("x4_same_cycle", 0, 64'h0, 1'b0);
`endif
    cycle();
    idle_inputs();
    chk_now("x4_after", 1, 64'h2, 1'b0);
    cycle();

    // Random traffic with address bias toward a few registers to force collisions.
    for (int c = 0; c < 10000; c++) begin
      rst       = ($urandom_range(0, 999) == 0);
      iss_valid = $urandom_range(0, 1) == 1;
      iss_rd    = ($urandom_range(0, 1) == 1) ? AW'($urandom_range(0, 7)) : AW'($urandom);
      for (int j = 0; j < int'(NW); j++) begin
        set_wb(j, $urandom_range(0, 2) == 0,
               ($urandom_range(0, 1) == 1) ? AW'($urandom_range(0, 7)) : AW'($urandom),
               {$urandom, $urandom});
      end
      for (int k = 0; k < int'(NR); k++) begin
        set_rd(k, ($urandom_range(0, 1) == 1) ? AW'($urandom_range(0, 7)) : AW'($urandom));
      end
      cycle();
    end
    rst = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port integer register file for the LemonPC core, with a per-register pending-write scoreboard and an optional write-to-read bypass. It sits between decode/issue and writeback. It gives decode any number of combinational read ports plus a busy flag per read. It accepts several writeback ports per cycle, and it replaces the single-read-pair, single-write register file of the previous core generation.

## Interface
- ADDR_WIDTH, 5, register index width; depth = 2**ADDR_WIDTH.
- DATA_WIDTH, 64, register width.
- NR_READ, 2, number of read ports (1..4).
- NR_WRITE, 1, number of writeback ports (1..2).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous and active-high.
- rd_addr  in  NR_READ*ADDR_WIDTH  read addresses; port k occupies bits [k*ADDR_WIDTH +: ADDR_WIDTH].
- rd_data  out  NR_READ*DATA_WIDTH  read data, same packing.
- rd_busy  out  NR_READ  1 = the addressed register has a pending write.
- iss_valid  in  1  an instruction with a destination issues this cycle.
- iss_rd  in  ADDR_WIDTH  destination of the issuing instruction.
- wb_en  in  NR_WRITE  per-port write enable.
- wb_addr  in  NR_WRITE*ADDR_WIDTH  per-port write address.
- wb_data  in  NR_WRITE*DATA_WIDTH  per-port write data.

## Operation
- Storage: the array rf[0..2**ADDR_WIDTH-1] and the busy vector busy[0..2**ADDR_WIDTH-1].
- Register x0:
  - reads always return 0 with busy 0;
  - writes to x0 are discarded;
  - an issue to x0 does not set busy.
- Write: on each edge, for every port j with wb_en[j] and wb_addr != 0, rf[wb_addr] <= wb_data.
- Same-address writes: if two ports write the same address in one cycle, the higher port index wins.
- Busy set: iss_valid with iss_rd != 0 sets busy[iss_rd] at the edge.
- Busy clear: a write from any port to address a clears busy[a] at the edge.
- Issue and writeback to the same register in one cycle: set wins, so busy stays 1. The new producer is still outstanding.
- Writeback to a register that is not busy: the data is written and busy stays 0. This is legal and is not an error.
- Read port k, without bypass: rd_data = rf[addr] and rd_busy = busy[addr], both combinational.
- Reads have no ordering constraint between ports; several ports may read the same address.

## Timing
- Reads are combinational: zero-cycle latency from rd_addr to rd_data/rd_busy.
- Writes and busy updates take effect at the rising edge and are visible on reads in the following cycle (without bypass).
- Reset, while rst is high at an edge:
  - every rf entry becomes 0;
  - every busy bit becomes 0;
  - iss_valid and wb_en are ignored in that cycle.
- Reset asserted mid-operation discards all pending state; there is no recovery of in-flight writes.
- After reset is released, rd_data = 0 and rd_busy = 0 for every address until the first write or issue.

## Configuration
- REGFILE_BYPASS_EN defined:
  - a read whose address matches an active write this cycle (wb_en[j], wb_addr == addr, addr != 0) returns wb_data of the highest matching port;
  - rd_busy is then 0, unless iss_valid && iss_rd == addr in the same cycle, in which case rd_busy = 1 and rd_data is the bypassed value.
- REGFILE_BYPASS_EN undefined:
  - reads see only array state;
  - the same-cycle writeback is visible one cycle later;
  - rd_busy stays 1 during the writeback cycle.
- Both builds reset, store and clear busy identically.

## Structure
- Shared package lemonpc_pkg holds:
  - default ADDR_WIDTH and DATA_WIDTH (XLEN);
  - the x0 index constant;
  - the read-port packing helper widths, reused by decode.
- One sub-module, regfile_rdport: a single read port containing the address mux, x0 forcing and the bypass compare chain. It is instantiated NR_READ times by a generate loop.
- Array, busy vector and write arbitration live in the top module.

## Test plan
- Reset: hold rst 1 for 2 cycles with wb_en = 1 to x5 = 0xAA → after release, every address reads 0 with busy 0; x5 reads 0.
- Basic write: write x3 = 0x1234 on port 0 → the next cycle, all read ports addressing x3 return 0x1234 with busy 0. A write of x0 = 0xFFFF reads back 0.
- Scoreboard: issue x7; two cycles later, writeback x7 = 0x55 → rd_busy for x7 is 1 for exactly those cycles, then 0 with data 0x55.
- Simultaneous issue and writeback to x9 → busy[x9] remains 1 the next cycle, and data is updated to the writeback value.
- Dual write (NR_WRITE = 2), same cycle:
  - port 0 x4 = 1 and port 1 x4 = 2 → x4 = 2;
  - with REGFILE_BYPASS_EN, a same-cycle read of x4 returns 2 with busy 0;
  - without it, the same-cycle read returns the old value with busy as before.
- Random test: 10k cycles of random issue, write and read on all ports, checked against a behavioural model of the array and scoreboard, run in both macro builds.
